fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port stall  input  1  load-use stall from the hazard unit; holds PC and IF/ID.
REQ-005 The block SHALL have port if_flush  input  1  redirect request from the controller; IF/ID becomes a bubble.
REQ-006 The block SHALL have ports pc_src, jmp, jr  input  1 each  redirect-type selects from the controller.
REQ-007 The block SHALL have ports branch_target  input  32, jr_addr  input  32, jump_index  input  26  redirect operands from ID.
REQ-008 The block SHALL have ports imem_req  output  1, imem_addr  output  32, imem_rdata  input  32, imem_ready  input  1  variable-latency instruction-memory handshake.
REQ-009 The block SHALL have ports if_id_instr  output  32, if_id_pc4  output  32, if_id_valid  output  1  IF/ID pipeline register.

Function
REQ-010 The block SHALL implement FSM states IDLE, FETCH, HOLD and DRAIN.
REQ-011 Redirect target SHALL be jr_addr if jr; else {if_id_pc4[31:28], jump_index, 2'b00} if jmp; else branch_target if pc_src; else pc+4.
REQ-012 A redirect SHALL occur only when if_flush=1 and stall=0; if_flush is ignored while stall=1.
REQ-013 imem_req SHALL be 1 exactly in FETCH and DRAIN; imem_addr SHALL equal pc in FETCH and stay stable while imem_req=1 and imem_ready=0.
REQ-014 IDLE SHALL last one cycle after reset release, then go to FETCH.
REQ-015 FETCH, ready=1, no redirect, stall=0: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay FETCH (back-to-back, one instruction per cycle at zero wait).
REQ-016 FETCH, ready=1, redirect: IF/ID <= {32'h0, 32'h0, valid=0}; pc <= redirect target; stay FETCH; fetched word dropped.
REQ-017 FETCH, ready=1, stall=1: IF/ID holds; imem_rdata captured in a one-entry skid register; pc <= pc+4; go HOLD.
REQ-018 FETCH, ready=0, redirect: IF/ID <= bubble; target stored in pc_pending; go DRAIN.
REQ-019 FETCH, ready=0, no redirect: IF/ID <= bubble if stall=0, else holds; stay FETCH.
REQ-020 HOLD: stall=1 holds everything; stall=0 and no redirect moves skid into IF/ID (pc4 = pc at entry) and goes FETCH; redirect discards skid, IF/ID <= bubble, pc <= target, goes FETCH.
REQ-021 DRAIN: keeps the old address until imem_ready=1, drops the returned word, then pc <= pc_pending and goes FETCH; IF/ID holds the bubble.
REQ-022 A second redirect during DRAIN SHALL overwrite pc_pending (last redirect wins).
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-024 Asserting rst_n=0 SHALL immediately set pc=RESET_PC, pc_pending=0, skid=0, state=IDLE, imem_req=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, including mid-transaction; any outstanding memory response is not consumed.

Structure
REQ-025 Opcode constants, the 32'h0 NOP and RESET_PC default SHALL live in the shared CPU package used by the controller.
REQ-026 Next-PC selection (REQ-011) SHALL be a combinational sub-module next_pc_sel; FSM, PC, skid and IF/ID registers stay in fetch_stage.

Verification
REQ-027 Zero-wait memory, no stall: after reset, addresses 0,4,8,... on consecutive cycles; if_id_pc4 = 4,8,12 with valid=1.
REQ-028 Ready asserted 3 cycles late on addr 8: addr 8 held 3 cycles, IF/ID bubbles (valid=0) meanwhile, then instr at pc4=12.
REQ-029 Stall with ready=1 at addr 16: IF/ID holds; release stall -> skid instr appears with pc4=20; next addr 20; no instruction lost or duplicated.
REQ-030 if_flush+jr, jr_addr=32'h40, while ready=0 on addr 24: addr 24 held until ready, word dropped, next request addr 32'h40, IF/ID valid=0 throughout.
REQ-031 if_flush+jmp, jump_index=26'h10, if_id_pc4=32'h1000_0008, ready=1: next addr 32'h1000_0040, IF/ID bubble; if_flush with stall=1 produces no redirect.
REQ-032 rst_n pulsed low mid-DRAIN: outputs at reset values asynchronously; after release, first address RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared CPU constants (opcodes, NOP, reset PC) and fetch FSM encoding.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// next_pc_sel: redirect target mux, priority jr > jmp > branch > sequential.
module next_pc_sel
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] if_id_pc4_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jr_addr_i,
    input  logic [25:0] jump_index_i,
    input  logic        pc_src_i,
    input  logic        jmp_i,
    input  logic        jr_i,
    output logic [31:0] target_o
);

    assign target_o = jr_i     ? jr_addr_i :
                      jmp_i    ? {if_id_pc4_i[31:28], jump_index_i, 2'b00} :
                      pc_src_i ? branch_target_i :
                                 pc_plus4(pc_i);

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, variable-latency imem handshake, one-entry skid and IF/ID register.
// A redirect that arrives while a request is outstanding is parked until the old response drains.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        if_flush,
    input  logic        pc_src,
    input  logic        jmp,
    input  logic        jr,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_addr,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic [31:0]  skid_q, skid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         req_q, req_d;
    logic [31:0]  target;
    logic [31:0]  pc_inc;
    logic         redirect;

    assign redirect = if_flush & ~stall;
    assign pc_inc   = pc_plus4(pc_q);

    next_pc_sel u_next_pc_sel (
        .pc_i            (pc_q),
        .if_id_pc4_i     (pc4_q),
        .branch_target_i (branch_target),
        .jr_addr_i       (jr_addr),
        .jump_index_i    (jump_index),
        .pc_src_i        (pc_src),
        .jmp_i           (jmp),
        .jr_i            (jr),
        .target_o        (target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        skid_d  = skid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        instr_d = NOP;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                        pc_d    = target;
                    end else if (stall) begin
                        skid_d  = imem_rdata;
                        pc_d    = pc_inc;
                        state_d = HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_inc;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end
                end else if (redirect) begin
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    pend_d  = target;
                    state_d = DRAIN;
                end else if (!stall) begin
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!stall) begin
                    // pc already advanced on entry, so it is the skid word's pc+4
                    instr_d = skid_q;
                    pc4_d   = pc_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                pend_d = redirect ? target : pend_q;
                if (imem_ready) begin
                    pc_d    = pend_d;
                    state_d = FETCH;
                end
            end
        endcase
        req_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            skid_q  <= '0;
            instr_q <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            skid_q  <= skid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized run against a transaction-level fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0, if_flush = 1'b0, pc_src = 1'b0, jmp = 1'b0, jr = 1'b0;
    logic [31:0] branch_target = '0, jr_addr = '0;
    logic [25:0] jump_index = '0;
    logic        imem_req, imem_ready = 1'b1;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid;
    logic [97:0] obs, e;
    int          checks = 0, errors = 0;

    // model: fetch address, parked redirect, captured-while-stalled words, IF/ID contents
    logic [31:0] m_pc, m_pend, m_instr, m_pc4;
    logic        m_valid, m_started, m_drop;
    logic [31:0] m_skid[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [97:0] pack(input logic r, input logic [31:0] a, input logic v,
                                         input logic [31:0] p4, input logic [31:0] ins);
        return {r, r ? a : 32'h0, v, p4, ins};
    endfunction

    assign imem_rdata = mem(imem_addr);
    assign obs = {imem_req, imem_req ? imem_addr : 32'h0, if_id_valid, if_id_pc4, if_id_instr};

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .if_flush(if_flush),
        .pc_src(pc_src), .jmp(jmp), .jr(jr),
        .branch_target(branch_target), .jr_addr(jr_addr), .jump_index(jump_index),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
    );

    function automatic void m_bubble();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endfunction

    function automatic void m_reset();
        m_pc = 32'h0; m_pend = 32'h0; m_started = 1'b0; m_drop = 1'b0;
        m_skid.delete();
        m_bubble();
    endfunction

    function automatic void m_step();
        logic        redir;
        logic [31:0] tgt;
        redir = if_flush && !stall;
        tgt = jr ? jr_addr : jmp ? {m_pc4[31:28], jump_index, 2'b00} : pc_src ? branch_target : m_pc + 32'd4;
        if (!m_started) m_started = 1'b1;
        else if (m_skid.size() != 0) begin
            if (redir) begin m_skid.delete(); m_bubble(); m_pc = tgt; end
            else if (!stall) begin m_instr = m_skid.pop_front(); m_pc4 = m_pc; m_valid = 1'b1; end
        end else if (m_drop) begin
            if (redir) m_pend = tgt;
            if (imem_ready) begin m_pc = m_pend; m_drop = 1'b0; end
        end else if (imem_ready) begin
            if (redir) begin m_bubble(); m_pc = tgt; end
            else if (stall) begin m_skid.push_back(mem(m_pc)); m_pc = m_pc + 32'd4; end
            else begin m_instr = mem(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4; end
        end else if (redir) begin m_bubble(); m_pend = tgt; m_drop = 1'b1; end
        else if (!stall) m_bubble();
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (obs !== pack(0, 0, 0, 0, 0) || imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_async: got %h addr %h exp all zero", obs, imem_addr);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        e = pack(1, 32'h0, 0, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_first_fetch: got %h exp %h", obs, e); end
    endtask

    task automatic test_zero_wait();
        for (int k = 1; k <= 2; k++) begin
            tick();
            e = pack(1, 4 * k, 1, 4 * k, mem(4 * k - 4)); checks++;
            if (obs !== e) begin errors++; $display("FAIL zero_wait_%0d: got %h exp %h", k, obs, e); end
        end
    endtask

    task automatic test_late_ready();
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            e = pack(1, 32'h8, 0, 0, 0); checks++;
            if (obs !== e) begin errors++; $display("FAIL late_wait_%0d: got %h exp %h", k, obs, e); end
        end
        imem_ready = 1'b1;
        tick();
        e = pack(1, 32'hC, 1, 32'hC, mem(32'h8)); checks++;
        if (obs !== e) begin errors++; $display("FAIL late_deliver: got %h exp %h", obs, e); end
        tick();
    endtask

    task automatic test_stall_skid();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            e = pack(0, 0, 1, 32'h10, mem(32'hC)); checks++;
            if (obs !== e) begin errors++; $display("FAIL stall_hold_%0d: got %h exp %h", k, obs, e); end
        end
        stall = 1'b0;
        tick();
        e = pack(1, 32'h14, 1, 32'h14, mem(32'h10)); checks++;
        if (obs !== e) begin errors++; $display("FAIL skid_release: got %h exp %h", obs, e); end
        tick();
        e = pack(1, 32'h18, 1, 32'h18, mem(32'h14)); checks++;
        if (obs !== e) begin errors++; $display("FAIL skid_next: got %h exp %h", obs, e); end
    endtask

    task automatic test_jr_drain();
        imem_ready = 1'b0; if_flush = 1'b1; jr = 1'b1; jr_addr = 32'h40;
        tick();
        if_flush = 1'b0; jr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            e = pack(1, 32'h18, 0, 0, 0); checks++;
            if (obs !== e) begin errors++; $display("FAIL drain_hold_%0d: got %h exp %h", k, obs, e); end
        end
        imem_ready = 1'b1;
        tick();
        e = pack(1, 32'h40, 0, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL drain_target: got %h exp %h", obs, e); end
        tick();
        e = pack(1, 32'h44, 1, 32'h44, mem(32'h40)); checks++;
        if (obs !== e) begin errors++; $display("FAIL drain_resume: got %h exp %h", obs, e); end
    endtask

    task automatic test_jmp();
        if_flush = 1'b1; jr = 1'b1; jr_addr = 32'h1000_0004;
        tick();
        if_flush = 1'b0; jr = 1'b0;
        tick();
        e = pack(1, 32'h1000_0008, 1, 32'h1000_0008, mem(32'h1000_0004)); checks++;
        if (obs !== e) begin errors++; $display("FAIL jmp_setup: got %h exp %h", obs, e); end
        stall = 1'b1; imem_ready = 1'b0; if_flush = 1'b1; jmp = 1'b1; jump_index = 26'h10;
        tick();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL flush_during_stall: got %h exp %h", obs, e); end
        stall = 1'b0; imem_ready = 1'b1;
        tick();
        e = pack(1, 32'h1000_0040, 0, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL jmp_target: got %h exp %h", obs, e); end
        if_flush = 1'b0; jmp = 1'b0;
    endtask

    task automatic test_last_redirect_wins();
        imem_ready = 1'b0; if_flush = 1'b1; jr = 1'b1; jr_addr = 32'h100;
        tick();
        jr_addr = 32'h200;
        tick();
        e = pack(1, 32'h1000_0040, 0, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL second_redirect_hold: got %h exp %h", obs, e); end
        if_flush = 1'b0; jr = 1'b0; imem_ready = 1'b1;
        tick();
        e = pack(1, 32'h200, 0, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL last_redirect_wins: got %h exp %h", obs, e); end
    endtask

    task automatic test_wrap();
        if_flush = 1'b1; jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
        tick();
        if_flush = 1'b0; jr = 1'b0;
        tick();
        e = pack(1, 32'h0, 1, 32'h0, mem(32'hFFFF_FFFC)); checks++;
        if (obs !== e) begin errors++; $display("FAIL pc_wrap: got %h exp %h", obs, e); end
        tick();
        e = pack(1, 32'h4, 1, 32'h4, mem(32'h0)); checks++;
        if (obs !== e) begin errors++; $display("FAIL pc_wrap_next: got %h exp %h", obs, e); end
    endtask

    task automatic test_reset_mid_drain();
        imem_ready = 1'b0; if_flush = 1'b1; jr = 1'b1; jr_addr = 32'h80;
        tick();
        if_flush = 1'b0; jr = 1'b0;
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if (obs !== pack(0, 0, 0, 0, 0) || imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mid_drain: got %h addr %h exp all zero", obs, imem_addr);
        end
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        e = pack(1, 32'h0, 0, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_restart: got %h exp %h", obs, e); end
        tick();
        e = pack(1, 32'h4, 1, 32'h4, mem(32'h0)); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_restart_fetch: got %h exp %h", obs, e); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            imem_ready    = ($urandom_range(0, 3) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            if_flush      = ($urandom_range(0, 6) == 0);
            jr            = $urandom_range(0, 1);
            jmp           = $urandom_range(0, 1);
            pc_src        = $urandom_range(0, 1);
            jr_addr       = $urandom() & 32'hFFFF_FFFC;
            branch_target = $urandom() & 32'hFFFF_FFFC;
            jump_index    = 26'($urandom());
            tick();
            e = pack(m_started && m_skid.size() == 0, m_pc, m_valid, m_pc4, m_instr); checks++;
            if (obs !== e) begin errors++; $display("FAIL random_%0d: got %h exp %h", n, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_late_ready();
        test_stall_skid();
        test_jr_drain();
        test_jmp();
        test_last_redirect_wins();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
